ct_l2cache_data_access_ctrl: RTL

- Sequencer directly upstream of the L2 data array SRAM wrapper.
- Accepts one 64-byte line request per handshake and breaks it into four 128-bit SRAM beats.
- Drives the active-low SRAM controls CEN, GWEN and the bit-wise WEN.
- Captures read data one cycle after issue into a 2-entry output FIFO, then streams beats to the consumer with valid/ready backpressure.

---
 rtl/ct_l2cache_data_access_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ct_l2cache_data_access_ctrl.sv
// L2 data-array access sequencer: splits 64-byte line requests into four 128-bit
// SRAM beats and returns read beats through a 2-entry FIFO with valid/ready.
module ct_l2cache_data_access_ctrl #(
  parameter int unsigned DATA_INDEX_WIDTH = 13
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst,
  input  logic                        req_vld,
  output logic                        req_ready,
  input  logic                        req_wr,
  input  logic [DATA_INDEX_WIDTH-3:0] req_idx,
  input  logic [511:0]                req_wdata,
  input  logic [63:0]                 req_wstrb,
  output logic                        rd_vld,
  input  logic                        rd_ready,
  output logic [127:0]                rd_data,
  output logic [1:0]                  rd_beat,
  output logic                        rd_last,
  output logic                        ctrl_busy,
  output logic                        data_cen,
  output logic                        data_gwen,
  output logic [127:0]                data_wen,
  output logic [DATA_INDEX_WIDTH-1:0] data_idx,
  output logic [127:0]                data_din,
  input  logic [127:0]                data_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                      state_q, state_d;
  logic [DATA_INDEX_WIDTH-3:0] idx_q;
  logic [511:0]                wdata_q;
  logic [63:0]                 wstrb_q;
  logic [1:0]                  beat_q;
  logic                        pend_q;
  logic [1:0]                  pend_beat_q;
  logic [127:0]                fifo_data [2];
  logic [1:0]                  fifo_beat [2];
  logic                        rd_ptr_q, wr_ptr_q;
  logic [1:0]                  cnt_q;

  logic        accept, pop, push, rd_issue, beat_adv;
  logic [2:0]  occ;
  logic [15:0] beat_strb;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_vld && req_ready;
  assign rd_vld    = (cnt_q != 2'd0);
  assign pop       = rd_vld && rd_ready;
  assign push      = pend_q;
  assign rd_data   = fifo_data[rd_ptr_q];
  assign rd_beat   = fifo_beat[rd_ptr_q];
  assign rd_last   = (rd_beat == 2'd3);
  assign ctrl_busy = (state_q != IDLE) || rd_vld || pend_q;

  // Slots already committed after this cycle's pop; a new read needs one free.
  assign occ       = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};
  assign rd_issue  = (state_q == READ) && (occ < 3'd2);

  // beat_q stays on 3 after the last beat so address/data hold while IDLE.
  assign beat_adv  = ((state_q == WRITE) || rd_issue) && (beat_q != 2'd3);

  assign beat_strb = wstrb_q[{beat_q, 4'b0000} +: 16];
  assign data_idx  = {idx_q, beat_q};
  assign data_din  = wdata_q[{beat_q, 7'b0000000} +: 128];

  always_comb begin
    state_d   = state_q;
    data_cen  = 1'b1;
    data_gwen = 1'b1;
    data_wen  = '1;
    case (state_q)
      IDLE: begin
        if (req_vld) state_d = req_wr ? WRITE : READ;
      end
      READ: begin
        if (rd_issue) begin
          data_cen = 1'b0;
          if (beat_q == 2'd3) state_d = IDLE;
        end
      end
      WRITE: begin
        data_gwen = 1'b0;
        data_cen  = ~(|beat_strb);
        for (int unsigned k = 0; k < 16; k++) begin
          data_wen[8*k +: 8] = {8{~beat_strb[k]}};
        end
        if (beat_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      beat_q       <= '0;
      pend_q       <= 1'b0;
      pend_beat_q  <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_beat[0] <= '0;
      fifo_beat[1] <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      assert (!(push && !pop && cnt_q == 2'd2));
      state_q <= state_d;
      if (accept) begin
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        beat_q  <= '0;
      end else if (beat_adv) begin
        beat_q <= beat_q + 2'd1;
      end
      pend_q      <= rd_issue;
      pend_beat_q <= beat_q;
      if (push) begin
        fifo_data[wr_ptr_q] <= data_dout;
        fifo_beat[wr_ptr_q] <= pend_beat_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
